// File: rtl/aes_inv_cipher_core_if.sv
// Bus bundle for aes_inv_cipher_core.
//   kld/key          : key load strobe and 128-bit cipher key (byte 0 in [127:120])
//   ld/text_in       : ciphertext load strobe and 128-bit ciphertext block
//   kready/busy/done : status levels and the one-cycle completion pulse
//   text_out         : plaintext, held until the next done
//   ld_err           : only with AES_INV_CIPHER_LD_ERR_EN, pulses after an ignored ld
// master = block user, slave = the core.
interface aes_inv_cipher_core_if;
  logic         kld;
  logic [127:0] key;
  logic         ld;
  logic [127:0] text_in;
  logic         kready;
  logic         busy;
  logic         done;
  logic [127:0] text_out;
`ifdef AES_INV_CIPHER_LD_ERR_EN
  logic         ld_err;
  modport master (output kld, key, ld, text_in,
                  input  kready, busy, done, text_out, ld_err);
  modport slave  (input  kld, key, ld, text_in,
                  output kready, busy, done, text_out, ld_err);
`else
  modport master (output kld, key, ld, text_in,
                  input  kready, busy, done, text_out);
  modport slave  (input  kld, key, ld, text_in,
                  output kready, busy, done, text_out);
`endif
endinterface

// File: rtl/aes_inv_cipher_core.sv
// AES-128 inverse cipher, one round per clock.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : aes_inv_cipher_core_if.slave (kld/key, ld/text_in, kready, busy, done, text_out)
// kld runs the forward key schedule (10 cycles) and keeps rk10; each ld then
// decrypts one block in 10 cycles, walking the key schedule backwards from rk10.
// Optional: define AES_INV_CIPHER_LD_ERR_EN to add bus.ld_err, a one-cycle pulse
// after any ld that is ignored (not READY, or coincident with kld).
module aes_inv_cipher_core (
  input  logic                         clk,
  input  logic                         rst,
  aes_inv_cipher_core_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, KEXP, READY, DEC} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] wk_q, wk_d;        // working round key
  logic [127:0] blk_q, blk_d;      // cipher state
  logic [127:0] rk10_q, rk10_d;
  logic [127:0] text_out_q, text_out_d;
  logic         done_q, done_d;
`ifdef AES_INV_CIPHER_LD_ERR_EN
  logic         ld_err_q, ld_err_d;
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h01;
    t = x;
    for (int unsigned i = 1; i < 8; i++) begin
      t = gmul(t, t);
      p = gmul(p, t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;   4'd2: return 8'h02;   4'd3: return 8'h04;
      4'd4: return 8'h08;   4'd5: return 8'h10;   4'd6: return 8'h20;
      4'd7: return 8'h40;   4'd8: return 8'h80;   4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: recover rk_i from rk_{i+1}.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows and InvSubBytes together (they commute)
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = 4 * ((c + 4 - r) % 4) + r;
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next state
  always_comb begin
    fsm_d = fsm_q;
    if (bus.kld) begin
      fsm_d = KEXP;
    end else begin
      case (fsm_q)
        KEXP:    if (cnt_q == 4'd1) fsm_d = READY;
        READY:   if (bus.ld)        fsm_d = DEC;
        DEC:     if (cnt_q == 4'd0) fsm_d = READY;
        default: fsm_d = fsm_q;
      endcase
    end
  end

  // Datapath: in KEXP the counter runs 10..1, in DEC 9..0 (counter = round index)
  always_comb begin
    logic [127:0] kf, rk_cur;
    cnt_d      = cnt_q;
    wk_d       = wk_q;
    blk_d      = blk_q;
    rk10_d     = rk10_q;
    text_out_d = text_out_q;
    done_d     = 1'b0;
`ifdef AES_INV_CIPHER_LD_ERR_EN
    ld_err_d   = 1'b0;
`endif
    kf     = key_fwd(wk_q, rcon(4'd11 - cnt_q));
    rk_cur = key_inv(wk_q, rcon(cnt_q + 4'd1));
    if (bus.kld) begin
      cnt_d = 4'd10;
      wk_d  = bus.key;
`ifdef AES_INV_CIPHER_LD_ERR_EN
      ld_err_d = bus.ld;
`endif
    end else begin
`ifdef AES_INV_CIPHER_LD_ERR_EN
      ld_err_d = bus.ld && (fsm_q != READY);
`endif
      case (fsm_q)
        KEXP: begin
          wk_d  = kf;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) rk10_d = kf;
        end
        READY: begin
          if (bus.ld) begin
            blk_d = bus.text_in ^ rk10_q;
            wk_d  = rk10_q;
            cnt_d = 4'd9;
          end
        end
        DEC: begin
          if (cnt_q != 4'd0) begin
            blk_d = inv_mix(inv_sr_sb(blk_q) ^ rk_cur);
            wk_d  = rk_cur;
            cnt_d = cnt_q - 4'd1;
          end else begin
            text_out_d = inv_sr_sb(blk_q) ^ rk_cur;
            done_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wk_q       <= '0;
      blk_q      <= '0;
      rk10_q     <= '0;
      text_out_q <= '0;
      done_q     <= 1'b0;
`ifdef AES_INV_CIPHER_LD_ERR_EN
      ld_err_q   <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      wk_q       <= wk_d;
      blk_q      <= blk_d;
      rk10_q     <= rk10_d;
      text_out_q <= text_out_d;
      done_q     <= done_d;
`ifdef AES_INV_CIPHER_LD_ERR_EN
      ld_err_q   <= ld_err_d;
`endif
    end
  end

  // kready is implied by state: rk10 is valid exactly in READY and DEC,
  // since only kld (-> KEXP) or rst (-> IDLE) leave that pair.
  always_comb begin
    bus.busy     = (fsm_q == KEXP) || (fsm_q == DEC);
    bus.kready   = (fsm_q == READY) || (fsm_q == DEC);
    bus.done     = done_q;
    bus.text_out = text_out_q;
`ifdef AES_INV_CIPHER_LD_ERR_EN
    bus.ld_err   = ld_err_q;
`endif
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
module tb_aes_inv_cipher_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_core_if bus ();
  aes_inv_cipher_core dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference AES (table based) ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int b = 0; b < 16; b++)
        t[b] = isb[s[b%4 + 4*((b/4 + 4 - b%4) % 4)]] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (rnd > 0) begin
          s[4*c]   = gm(t[4*c], 14) ^ gm(t[4*c+1], 11) ^ gm(t[4*c+2], 13) ^ gm(t[4*c+3], 9);
          s[4*c+1] = gm(t[4*c], 9)  ^ gm(t[4*c+1], 14) ^ gm(t[4*c+2], 11) ^ gm(t[4*c+3], 13);
          s[4*c+2] = gm(t[4*c], 13) ^ gm(t[4*c+1], 9)  ^ gm(t[4*c+2], 14) ^ gm(t[4*c+3], 11);
          s[4*c+3] = gm(t[4*c], 11) ^ gm(t[4*c+1], 13) ^ gm(t[4*c+2], 9)  ^ gm(t[4*c+3], 14);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
    end
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  // ---------------- cycle behaviour model ----------------
  typedef enum {M_IDLE, M_KEXP, M_READY, M_DEC} mode_t;
  mode_t        m_mode = M_IDLE;
  int           m_t;
  logic [127:0] m_key, m_pt, m_text_out;
  bit           m_done, m_kready, m_ld_err;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    m_done   = 1'b0;
    m_ld_err = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_kready = 1'b0; m_text_out = '0; m_valid = 1'b1;
    end else if (bus.kld) begin
      m_mode = M_KEXP; m_t = 10; m_kready = 1'b0; m_key = bus.key;
      m_ld_err = bus.ld;
    end else begin
      if (bus.ld && m_mode != M_READY) m_ld_err = 1'b1;
      case (m_mode)
        M_KEXP: begin
          m_t--;
          if (m_t == 0) begin m_mode = M_READY; m_kready = 1'b1; end
        end
        M_READY: if (bus.ld) begin
          m_mode = M_DEC; m_t = 10; m_pt = ref_dec(m_key, bus.text_in);
        end
        M_DEC: begin
          m_t--;
          if (m_t == 0) begin m_mode = M_READY; m_text_out = m_pt; m_done = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", bus.busy, (m_mode == M_KEXP) || (m_mode == M_DEC));
      chk("kready", bus.kready, m_kready);
      chk("done", bus.done, m_done);
      chk("text_out", bus.text_out, m_text_out);
`ifdef AES_INV_CIPHER_LD_ERR_EN
      chk("ld_err", bus.ld_err, m_ld_err);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_kld(input logic [127:0] k);
    bus.kld = 1'b1; bus.key = k;
    @(negedge clk);
    bus.kld = 1'b0;
  endtask

  task automatic wait_kready();
    for (int i = 0; i < 30 && bus.kready !== 1'b1; i++) @(negedge clk);
    chk("kready_wait", bus.kready, 1'b1);
  endtask

  task automatic ld_and_wait(input logic [127:0] ct, output logic [127:0] pt);
    int lat;
    lat = 0;
    bus.ld = 1'b1; bus.text_in = ct;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.ld = 1'b0;
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    chk("latency", lat, 11);
    pt = bus.text_out;
  endtask

  logic [127:0] pt;

  initial begin
    build_tables();
    rst = 1'b1; bus.kld = 1'b0; bus.ld = 1'b0; bus.key = '0; bus.text_in = '0;
    cyc(2);
    rst = 1'b0;

    // model pinned against known-answer vectors
    chk("model_kat1", ref_dec(K1, C1), P1);
    chk("model_kat2", ref_dec(K2, C2), P2);
    chk("reset_text", bus.text_out, '0);

    // first known-answer decryption
    do_kld(K1);
    wait_kready();
    ld_and_wait(C1, pt);
    chk("kat1", pt, P1);

    // second key, then back-to-back in the done cycle without kld
    do_kld(K2);
    wait_kready();
    ld_and_wait(C2, pt);
    chk("kat2", pt, P2);
    ld_and_wait(C1, pt);
    chk("b2b", pt, ref_dec(K2, C1));

    // kld 4 cycles into DEC aborts; new key used next
    bus.ld = 1'b1; bus.text_in = C2;
    @(negedge clk);
    bus.ld = 1'b0;
    cyc(3);
    do_kld(K1);
    wait_kready();
    ld_and_wait(C1, pt);
    chk("abort_newkey", pt, P1);

    // reset mid-DEC, then ld without kld is ignored
    bus.ld = 1'b1; bus.text_in = C1;
    @(negedge clk);
    bus.ld = 1'b0;
    cyc(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_text", bus.text_out, '0);
    bus.ld = 1'b1; bus.text_in = C1;
    @(negedge clk);
    bus.ld = 1'b0;
    cyc(12);
    chk("idle_ld_text", bus.text_out, '0);

    // ld during DEC ignored, ld with kld ignored
    do_kld(K2);
    wait_kready();
    bus.ld = 1'b1; bus.text_in = C2;
    @(negedge clk);
    bus.ld = 1'b0;
    cyc(2);
    bus.ld = 1'b1; bus.text_in = C1;
    @(negedge clk);
    bus.ld = 1'b0;
    cyc(8);
    chk("dec_ld_text", bus.text_out, P2);
    bus.ld = 1'b1; bus.kld = 1'b1; bus.key = K1; bus.text_in = C2;
    @(negedge clk);
    bus.ld = 1'b0; bus.kld = 1'b0;
    wait_kready();
    chk("kld_ld_text", bus.text_out, P2);
    ld_and_wait(C1, pt);
    chk("after_kld_ld", pt, P1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom % 300) == 0;
      bus.kld     = ($urandom % 50) == 0;
      bus.key     = {$urandom, $urandom, $urandom, $urandom};
      bus.ld      = ($urandom % 3) == 0;
      bus.text_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b0; bus.kld = 1'b0; bus.ld = 1'b0;
    cyc(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
